// File: rtl/div_unit.sv
`default_nettype none
// =============================================================================
// div_unit : sequential signed restoring divider (quotient->Lo, remainder->Hi)
// Revision  : 1.0
// =============================================================================
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] DivA,
  input  logic [WIDTH-1:0] DivB,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sgnq_q, sgnq_d;
  logic             sgnr_q, sgnr_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    sgnq_d  = sgnq_q;
    sgnr_d  = sgnr_q;
    done_d  = 1'b0;
    dz_d    = 1'b0;
    // Partial remainder is WIDTH+1 bits only transiently; once restored it fits WIDTH.
    shifted = {rem_q, dvd_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_q};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (DivB == '0) begin
            dz_d = 1'b1;
          end else begin
            sgnq_d  = DivA[WIDTH-1] ^ DivB[WIDTH-1];
            sgnr_d  = DivA[WIDTH-1];
            dvd_d   = DivA[WIDTH-1] ? -DivA : DivA;
            dvs_d   = DivB[WIDTH-1] ? -DivB : DivB;
            rem_d   = '0;
            cnt_d   = CW'(WIDTH);
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        lo_d    = sgnq_q ? -dvd_q : dvd_q;
        hi_d    = sgnr_q ? -rem_q : rem_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      sgnq_q  <= 1'b0;
      sgnr_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      sgnq_q  <= sgnq_d;
      sgnr_q  <= sgnr_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign div_zero = dz_q;
  assign Hi       = hi_q;
  assign Lo       = lo_q;

endmodule
`default_nettype wire
